frame_min_max_tracker: RTL and testbench

Sequential stage directly downstream of `n_bit_magnitude_comparator`. It consumes a valid/ready stream of unsigned samples in fixed-length frames. For each frame it tracks the running maximum and minimum by comparing every accepted sample against the stored extremes. At frame end it presents max, min and an all-equal flag on a held valid/ready output until the consumer accepts them.

---
 rtl/frame_min_max_tracker_pkg.sv | 19 +
 rtl/n_bit_magnitude_comparator.sv | 16 +
 rtl/frame_min_max_tracker.sv | 158 +++++++++++++++
 tb/tb_frame_min_max_tracker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_min_max_tracker_pkg.sv
// Shared definitions for the frame min/max tracker: state encoding,
// default geometry and the frame counter width helper.
package tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned TRK_WIDTH     = 10;
    localparam int unsigned TRK_FRAME_LEN = 8;

    // Counter must be able to hold FRAME_LEN itself, not just FRAME_LEN-1.
    function automatic int unsigned cnt_width(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/n_bit_magnitude_comparator.sv
// Unsigned magnitude comparator: exactly one of g_t / e / l_t is high.
module n_bit_magnitude_comparator #(
    parameter int unsigned WIDTH = 10
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             g_t,
    output logic             e,
    output logic             l_t
);

    assign g_t = (a > b);
    assign e   = (a == b);
    assign l_t = (a < b);

endmodule

// File: rtl/frame_min_max_tracker.sv
// Per-frame running max/min over a valid/ready sample stream, result held
// until accepted. Define TRACKER_INDEX_EN to add first-occurrence indices.
module frame_min_max_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned WIDTH     = TRK_WIDTH,
    parameter int unsigned FRAME_LEN = TRK_FRAME_LEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             max_val,
    output logic [WIDTH-1:0]             min_val,
`ifdef TRACKER_INDEX_EN
    output logic [$clog2(FRAME_LEN)-1:0] max_idx,
    output logic [$clog2(FRAME_LEN)-1:0] min_idx,
`endif
    output logic                         all_eq
);

    localparam int unsigned CW = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] run_max;
    logic [WIDTH-1:0] run_min;
    logic [WIDTH-1:0] nxt_max;
    logic [WIDTH-1:0] nxt_min;
    logic             gt_max;
    logic             lt_min;
    logic             eq_nxt;
    logic             unused_cmp_max_e, unused_cmp_max_l;
    logic             unused_cmp_min_g, unused_cmp_min_e;
    logic             unused_cmp_eq_g, unused_cmp_eq_l;

    n_bit_magnitude_comparator #(.WIDTH(WIDTH)) u_cmp_max (
        .a   (in_data),
        .b   (run_max),
        .g_t (gt_max),
        .e   (unused_cmp_max_e),
        .l_t (unused_cmp_max_l)
    );

    n_bit_magnitude_comparator #(.WIDTH(WIDTH)) u_cmp_min (
        .a   (in_data),
        .b   (run_min),
        .g_t (unused_cmp_min_g),
        .e   (unused_cmp_min_e),
        .l_t (lt_min)
    );

    // Strict compares keep the first occurrence on ties.
    assign nxt_max = gt_max ? in_data : run_max;
    assign nxt_min = lt_min ? in_data : run_min;

    n_bit_magnitude_comparator #(.WIDTH(WIDTH)) u_cmp_eq (
        .a   (nxt_max),
        .b   (nxt_min),
        .g_t (unused_cmp_eq_g),
        .e   (eq_nxt),
        .l_t (unused_cmp_eq_l)
    );

    assign in_ready = (state != DONE);

`ifdef TRACKER_INDEX_EN
    localparam int unsigned IW = $clog2(FRAME_LEN);
    logic [IW-1:0] run_max_idx;
    logic [IW-1:0] run_min_idx;
    logic [IW-1:0] nxt_max_idx;
    logic [IW-1:0] nxt_min_idx;

    // Before the increment, cnt equals the 0-based position of this sample.
    assign nxt_max_idx = gt_max ? cnt[IW-1:0] : run_max_idx;
    assign nxt_min_idx = lt_min ? cnt[IW-1:0] : run_min_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max_idx <= '0;
            run_min_idx <= '0;
            max_idx     <= '0;
            min_idx     <= '0;
        end else if (!clr && in_valid) begin
            if (state == IDLE) begin
                run_max_idx <= '0;
                run_min_idx <= '0;
            end else if (state == ACCUM) begin
                run_max_idx <= nxt_max_idx;
                run_min_idx <= nxt_min_idx;
                if (cnt == LAST_CNT) begin
                    max_idx <= nxt_max_idx;
                    min_idx <= nxt_min_idx;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            run_max   <= '0;
            run_min   <= '0;
            max_val   <= '0;
            min_val   <= '0;
            all_eq    <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        run_max <= in_data;
                        run_min <= in_data;
                        cnt     <= CW'(1);
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        run_max <= nxt_max;
                        run_min <= nxt_min;
                        cnt     <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            max_val   <= nxt_max;
                            min_val   <= nxt_min;
                            all_eq    <= eq_nxt;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_min_max_tracker.sv
// Scoreboard bench for frame_min_max_tracker (WIDTH=10, FRAME_LEN=4):
// a frame-level reference model predicts results, a monitor checks outputs.
module tb_frame_min_max_tracker;

    localparam int unsigned W  = 10;
    localparam int unsigned FL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  max_val;
    logic [W-1:0]  min_val;
    logic          all_eq;
`ifdef TRACKER_INDEX_EN
    logic [$clog2(FL)-1:0] max_idx;
    logic [$clog2(FL)-1:0] min_idx;
`endif

    frame_min_max_tracker #(.WIDTH(W), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_val   (max_val),
        .min_val   (min_val),
`ifdef TRACKER_INDEX_EN
        .max_idx   (max_idx),
        .min_idx   (min_idx),
`endif
        .all_eq    (all_eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned mx;
        int unsigned mn;
        int unsigned eq;
        int unsigned mxi;
        int unsigned mni;
    } res_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    res_t        exp_q[$];
    int unsigned frame_q[$];
    bit          m_done = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t frame_result(input int unsigned f[$]);
        res_t r;
        r.mx = f[0]; r.mn = f[0]; r.mxi = 0; r.mni = 0;
        foreach (f[i]) begin
            if (f[i] > r.mx) begin r.mx = f[i]; r.mxi = i; end
            if (f[i] < r.mn) begin r.mn = f[i]; r.mni = i; end
        end
        r.eq = (r.mx == r.mn) ? 1 : 0;
        return r;
    endfunction

    // Reference model: frame-level bookkeeping using only bench-driven inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q.delete();
            exp_q.delete();
            m_done = 1'b0;
        end else if (clr) begin
            frame_q.delete();
            if (m_done) void'(exp_q.pop_back());
            m_done = 1'b0;
        end else if (m_done) begin
            if (out_ready) begin
                void'(exp_q.pop_front());
                m_done = 1'b0;
            end
        end else if (in_valid) begin
            frame_q.push_back(int'(in_data));
            if (frame_q.size() == FL) begin
                exp_q.push_back(frame_result(frame_q));
                frame_q.delete();
                m_done = 1'b1;
            end
        end
    end

    // Monitor: away from the active edge, compare handshake and held result.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, m_done ? 0 : 1);
            check("out_valid", out_valid, m_done ? 1 : 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got out_valid 1 expected no result at %0t", $time);
                end else begin
                    check("max_val", max_val, exp_q[0].mx);
                    check("min_val", min_val, exp_q[0].mn);
                    check("all_eq", all_eq, exp_q[0].eq);
`ifdef TRACKER_INDEX_EN
                    check("max_idx", max_idx, exp_q[0].mxi);
                    check("min_idx", min_idx, exp_q[0].mni);
`endif
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        @(negedge clk);
    endtask

    task automatic send_frame(input int unsigned s0, s1, s2, s3);
        drive(1'b1, W'(s0), 1'b1, 1'b0);
        drive(1'b1, W'(s1), 1'b1, 1'b0);
        drive(1'b1, W'(s2), 1'b1, 1'b0);
        drive(1'b1, W'(s3), 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        clr      = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_max_val", max_val, 0);
        check("rst_min_val", min_val, 0);
        check("rst_all_eq", all_eq, 0);
`ifdef TRACKER_INDEX_EN
        check("rst_max_idx", max_idx, 0);
        check("rst_min_idx", min_idx, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_data();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(500 + $urandom_range(0, 2));
            default: return W'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready_init", in_ready, 1);
        check("rst_out_valid_init", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send_frame(60, 51, 42, 61);
        send_frame(42, 42, 42, 42);
        send_frame(0, 1023, 1023, 0);

        // Backpressure: result held while 999 is offered and must be ignored.
        drive(1'b1, W'(300), 1'b0, 1'b0);
        drive(1'b1, W'(100), 1'b0, 1'b0);
        drive(1'b1, W'(200), 1'b0, 1'b0);
        drive(1'b1, W'(150), 1'b0, 1'b0);
        repeat (5) drive(1'b1, W'(999), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        send_frame(7, 3, 9, 3);

        // Clear mid-frame, including a sample offered in the clear cycle.
        drive(1'b1, W'(10), 1'b1, 1'b0);
        drive(1'b1, W'(20), 1'b1, 1'b0);
        drive(1'b1, W'(1000), 1'b1, 1'b1);
        send_frame(5, 6, 7, 8);

        // Reset mid-frame, then while a result is held.
        drive(1'b1, W'(900), 1'b1, 1'b0);
        drive(1'b1, W'(901), 1'b1, 1'b0);
        pulse_reset();
        drive(1'b1, W'(11), 1'b0, 1'b0);
        drive(1'b1, W'(12), 1'b0, 1'b0);
        drive(1'b1, W'(13), 1'b0, 1'b0);
        drive(1'b1, W'(14), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        pulse_reset();
        send_frame(400, 401, 399, 400);

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_data(),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
